dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
Issue-stage sequencer between the decoder and the combinational Dispatch block. It holds one decoded instruction in a skid register and tracks free-slot credits for ROB, RS and LSB. It raises Dispatch_S only when every resource the instruction needs has a free slot, and it handles misprediction flush.

Parameters:
ROB_SIZE, 16, ROB entries; width of the ROB credit counter is clog2(ROB_SIZE+1).
RS_SIZE, 16, reservation-station entries.
LSB_SIZE, 16, load/store buffer entries.
OP_WIDTH, 6, width of the internal Op encoding.

Ports:
clk_in  in  1  clock; all state updates on rising edge
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; when 0 all state holds and Dispatch_S=0
clear  in  1  ROB misprediction flush pulse
id_valid  in  1  decoder presents an instruction
id_op  in  OP_WIDTH  decoded Op
id_a  in  32  immediate
id_rd  in  5  destination register
id_pc  in  32  instruction PC
id_stall  out  1  decoder must hold its current instruction
Dispatch_S  out  1  dispatch the buffered instruction this cycle
dis_op  out  OP_WIDTH  buffered Op
dis_a  out  32  buffered immediate
dis_rd  out  5  buffered rd
dis_pc  out  32  buffered PC
rob_release  in  1  one ROB entry committed this cycle
rs_release  in  1  one RS entry issued to ALU this cycle
lsb_release  in  1  one LSB entry retired this cycle
lsb_live_cnt  in  clog2(LSB_SIZE+1)  committed stores surviving a flush
credit_err  out  1  sticky; a release arrived while that counter was at max

Behaviour:
- State machine: RUN, FLUSH.
- Reset values: state=RUN, buf_valid=0, rob_free=ROB_SIZE, rs_free=RS_SIZE, lsb_free=LSB_SIZE, credit_err=0. All dis_* outputs are 0 and Dispatch_S=0.
- Op classification is combinational and done by the op_class sub-module:
  - is_ls covers LB, LH, LW, LBU, LHU, SB, SH, SW.
  - Every instruction needs one ROB slot.
  - is_ls needs one LSB slot; all other instructions need one RS slot.
- can_go = buf_valid & rob_free!=0 & (is_ls ? lsb_free!=0 : rs_free!=0).
- Dispatch_S = can_go & rdy_in & !clear & state==RUN. This is combinational from registers and clear only; it never depends on id_*.
- id_stall = buf_valid & !Dispatch_S, or state==FLUSH, or clear.
- Buffer load: on a clock edge with rdy_in=1, id_valid=1 and id_stall=0, the buffer takes id_* and buf_valid becomes 1. A dispatch and a load can happen in the same cycle, giving back-to-back throughput of 1 per cycle.
- If Dispatch_S=1 and no load happens, buf_valid becomes 0.
- Counter update each edge with rdy_in=1:
  - Each counter's next value = free - consume + release, where consume comes from Dispatch_S and the class.
  - A simultaneous consume and release leaves the counter unchanged.
  - A release when free==SIZE and there is no consume leaves the counter at SIZE and sets credit_err.
- Counters never underflow, because Dispatch_S requires free!=0.
- clear=1 (with rdy_in=1) has priority over everything. At that edge:
  - buf_valid becomes 0.
  - rob_free becomes ROB_SIZE and rs_free becomes RS_SIZE.
  - lsb_free becomes LSB_SIZE - lsb_live_cnt.
  - state becomes FLUSH.
  - Release pulses in the same cycle are ignored.
- FLUSH lasts exactly one cycle. Releases in that cycle apply normally. The next state is RUN.
- rdy_in=0 freezes all state, including a pending clear. clear is sampled only when rdy_in=1.
- Asserting rst_in mid-operation immediately returns every output to its reset value.

Decomposition:
- Shared package holds:
  - the Op encodings (LB..SW, BEQ..BGEU and the rest) and OpBus, DataBus, RegBus widths, shared with the decoder and Dispatch;
  - the state encoding for RUN and FLUSH.
- One sub-module, op_class: combinational Op -> is_ls decode, reusable by Dispatch.

Test Plan:
- Reset, then id_valid with LW and SIZE=16 -> Dispatch_S=1 on the cycle after load; lsb_free 16->15, rob_free 16->15, rs_free stays 16.
- 16 ADDs back-to-back with no rs_release -> 16 dispatches. The 17th is held: Dispatch_S=0, id_stall=1. One rs_release and one rob_release -> the 17th dispatches the next cycle.
- rs_free=1 with dispatch and rs_release in the same cycle -> rs_free stays 1 and the next ADD dispatches.
- clear with buffer full, rob_free=3 and lsb_live_cnt=2 -> buffer dropped, rob_free=16, rs_free=16, lsb_free=14. id_stall=1 for the clear cycle and the FLUSH cycle, then 0.
- rdy_in=0 for 5 cycles with an instruction buffered and releases pulsing -> no dispatch and all counters unchanged.
- rob_release while rob_free=16 -> rob_free stays 16 and credit_err=1 stays set until reset.

Source files
------------

// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the issue stage: Op encodings, bus widths, sequencer
// states and the credit-counter update helper.
package dispatch_ctrl_pkg;

  localparam int OP_BUS_W   = 6;
  localparam int DATA_BUS_W = 32;
  localparam int REG_BUS_W  = 5;

  typedef logic [OP_BUS_W-1:0]   op_bus_t;
  typedef logic [DATA_BUS_W-1:0] data_bus_t;
  typedef logic [REG_BUS_W-1:0]  reg_bus_t;

  localparam op_bus_t OP_NOP   = 6'd0;
  localparam op_bus_t OP_LUI   = 6'd1;
  localparam op_bus_t OP_AUIPC = 6'd2;
  localparam op_bus_t OP_JAL   = 6'd3;
  localparam op_bus_t OP_JALR  = 6'd4;
  localparam op_bus_t OP_BEQ   = 6'd5;
  localparam op_bus_t OP_BNE   = 6'd6;
  localparam op_bus_t OP_BLT   = 6'd7;
  localparam op_bus_t OP_BGE   = 6'd8;
  localparam op_bus_t OP_BLTU  = 6'd9;
  localparam op_bus_t OP_BGEU  = 6'd10;
  localparam op_bus_t OP_LB    = 6'd11;
  localparam op_bus_t OP_LH    = 6'd12;
  localparam op_bus_t OP_LW    = 6'd13;
  localparam op_bus_t OP_LBU   = 6'd14;
  localparam op_bus_t OP_LHU   = 6'd15;
  localparam op_bus_t OP_SB    = 6'd16;
  localparam op_bus_t OP_SH    = 6'd17;
  localparam op_bus_t OP_SW    = 6'd18;
  localparam op_bus_t OP_ADDI  = 6'd19;
  localparam op_bus_t OP_SLTI  = 6'd20;
  localparam op_bus_t OP_SLTIU = 6'd21;
  localparam op_bus_t OP_XORI  = 6'd22;
  localparam op_bus_t OP_ORI   = 6'd23;
  localparam op_bus_t OP_ANDI  = 6'd24;
  localparam op_bus_t OP_SLLI  = 6'd25;
  localparam op_bus_t OP_SRLI  = 6'd26;
  localparam op_bus_t OP_SRAI  = 6'd27;
  localparam op_bus_t OP_ADD   = 6'd28;
  localparam op_bus_t OP_SUB   = 6'd29;
  localparam op_bus_t OP_SLL   = 6'd30;
  localparam op_bus_t OP_SLT   = 6'd31;
  localparam op_bus_t OP_SLTU  = 6'd32;
  localparam op_bus_t OP_XOR   = 6'd33;
  localparam op_bus_t OP_SRL   = 6'd34;
  localparam op_bus_t OP_SRA   = 6'd35;
  localparam op_bus_t OP_OR    = 6'd36;
  localparam op_bus_t OP_AND   = 6'd37;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // A matched take/give cancels; a give at full is dropped (caller flags it).
  function automatic logic [31:0] credit_next(input logic [31:0] free,
                                              input logic [31:0] size,
                                              input logic take,
                                              input logic give);
    if (take && !give) return free - 32'd1;
    if (give && !take && free != size) return free + 32'd1;
    return free;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_op_class.sv
// Combinational Op classifier: flags loads and stores, which occupy the LSB
// instead of a reservation station.
module dispatch_ctrl_op_class
  import dispatch_ctrl_pkg::*;
(
  input  op_bus_t op,
  output logic    is_ls
);

  always_comb begin
    is_ls = 1'b0;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_ls = 1'b1;
      default: is_ls = 1'b0;
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Issue-stage sequencer: one-entry skid buffer plus ROB/RS/LSB free-slot
// credits, gating Dispatch_S and recovering after a misprediction flush.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_SIZE = 16,
  parameter int RS_SIZE  = 16,
  parameter int LSB_SIZE = 16,
  parameter int OP_WIDTH = OP_BUS_W,
  localparam int ROB_W   = $clog2(ROB_SIZE + 1),
  localparam int RS_W    = $clog2(RS_SIZE + 1),
  localparam int LSB_W   = $clog2(LSB_SIZE + 1)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                clear,
  input  logic                id_valid,
  input  logic [OP_WIDTH-1:0] id_op,
  input  logic [31:0]         id_a,
  input  logic [4:0]          id_rd,
  input  logic [31:0]         id_pc,
  output logic                id_stall,
  output logic                Dispatch_S,
  output logic [OP_WIDTH-1:0] dis_op,
  output logic [31:0]         dis_a,
  output logic [4:0]          dis_rd,
  output logic [31:0]         dis_pc,
  input  logic                rob_release,
  input  logic                rs_release,
  input  logic                lsb_release,
  input  logic [LSB_W-1:0]    lsb_live_cnt,
  output logic                credit_err,
  output state_t              dbg_state,
  output logic                dbg_buf_valid,
  output logic [ROB_W-1:0]    dbg_rob_free,
  output logic [RS_W-1:0]     dbg_rs_free,
  output logic [LSB_W-1:0]    dbg_lsb_free
);

  state_t           state_q, state_d;
  logic             buf_valid;
  logic [ROB_W-1:0] rob_free, rob_free_nxt;
  logic [RS_W-1:0]  rs_free, rs_free_nxt;
  logic [LSB_W-1:0] lsb_free, lsb_free_nxt;
  logic             is_ls, can_go, load, ovf;

  dispatch_ctrl_op_class u_op_class (
    .op    (op_bus_t'(dis_op)),
    .is_ls (is_ls)
  );

  assign can_go = buf_valid && (rob_free != '0) &&
                  (is_ls ? (lsb_free != '0) : (rs_free != '0));

  // Handshake: the buffer accepts id_* on an edge where rdy_in & id_valid & !id_stall;
  // the decoder holds id_* stable while id_stall is high.
  always_comb begin
    state_d    = state_q;
    Dispatch_S = 1'b0;
    id_stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        Dispatch_S = can_go && rdy_in && !clear;
        id_stall   = (buf_valid && !Dispatch_S) || clear;
        if (clear) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        id_stall = 1'b1;
        state_d  = clear ? ST_FLUSH : ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign load = rdy_in && id_valid && !id_stall;

  always_comb begin
    rob_free_nxt = ROB_W'(credit_next(32'(rob_free), 32'(ROB_SIZE), Dispatch_S, rob_release));
    rs_free_nxt  = RS_W'(credit_next(32'(rs_free), 32'(RS_SIZE), Dispatch_S && !is_ls,
                                     rs_release));
    lsb_free_nxt = LSB_W'(credit_next(32'(lsb_free), 32'(LSB_SIZE), Dispatch_S && is_ls,
                                      lsb_release));
    ovf = (rob_release && !Dispatch_S && rob_free == ROB_W'(ROB_SIZE)) ||
          (rs_release && !(Dispatch_S && !is_ls) && rs_free == RS_W'(RS_SIZE)) ||
          (lsb_release && !(Dispatch_S && is_ls) && lsb_free == LSB_W'(LSB_SIZE));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      buf_valid  <= 1'b0;
      rob_free   <= ROB_W'(ROB_SIZE);
      rs_free    <= RS_W'(RS_SIZE);
      lsb_free   <= LSB_W'(LSB_SIZE);
      credit_err <= 1'b0;
      dis_op     <= '0;
      dis_a      <= '0;
      dis_rd     <= '0;
      dis_pc     <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      if (clear) begin
        // Committed stores still own their LSB slots across the flush.
        buf_valid <= 1'b0;
        rob_free  <= ROB_W'(ROB_SIZE);
        rs_free   <= RS_W'(RS_SIZE);
        lsb_free  <= LSB_W'(LSB_SIZE) - lsb_live_cnt;
      end else begin
        rob_free   <= rob_free_nxt;
        rs_free    <= rs_free_nxt;
        lsb_free   <= lsb_free_nxt;
        credit_err <= credit_err | ovf;
        if (load) begin
          buf_valid <= 1'b1;
          dis_op    <= id_op;
          dis_a     <= id_a;
          dis_rd    <= id_rd;
          dis_pc    <= id_pc;
        end else if (Dispatch_S) begin
          buf_valid <= 1'b0;
        end
      end
    end
  end

  assign dbg_state     = state_q;
  assign dbg_buf_valid = buf_valid;
  assign dbg_rob_free  = rob_free;
  assign dbg_rs_free   = rs_free;
  assign dbg_lsb_free  = lsb_free;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: credit gating, back-to-back issue, flush
// recovery, rdy_in freeze and sticky credit error.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, id_valid;
  logic [5:0]  id_op;
  logic [31:0] id_a, id_pc;
  logic [4:0]  id_rd;
  logic        id_stall, Dispatch_S;
  logic [5:0]  dis_op;
  logic [31:0] dis_a, dis_pc;
  logic [4:0]  dis_rd;
  logic        rob_release, rs_release, lsb_release;
  logic [4:0]  lsb_live_cnt;
  logic        credit_err;
  state_t      dbg_state;
  logic        dbg_buf_valid;
  logic [4:0]  dbg_rob_free, dbg_rs_free, dbg_lsb_free;

  int checks = 0;
  int failures = 0;

  dispatch_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .id_valid(id_valid), .id_op(id_op), .id_a(id_a), .id_rd(id_rd), .id_pc(id_pc),
    .id_stall(id_stall), .Dispatch_S(Dispatch_S),
    .dis_op(dis_op), .dis_a(dis_a), .dis_rd(dis_rd), .dis_pc(dis_pc),
    .rob_release(rob_release), .rs_release(rs_release), .lsb_release(lsb_release),
    .lsb_live_cnt(lsb_live_cnt), .credit_err(credit_err),
    .dbg_state(dbg_state), .dbg_buf_valid(dbg_buf_valid),
    .dbg_rob_free(dbg_rob_free), .dbg_rs_free(dbg_rs_free), .dbg_lsb_free(dbg_lsb_free)
  );

  // Clock and reset
  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clear = 1'b0; id_valid = 1'b0; id_op = OP_NOP;
    id_a = '0; id_rd = '0; id_pc = '0;
    rob_release = 1'b0; rs_release = 1'b0; lsb_release = 1'b0; lsb_live_cnt = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_dispatch", 32'(Dispatch_S), 0);
    chk("rst_stall", 32'(id_stall), 0);
    chk("rst_dis_op", 32'(dis_op), 0);
    chk("rst_dis_pc", dis_pc, 0);
    chk("rst_err", 32'(credit_err), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
    chk("rst_rob", 32'(dbg_rob_free), 16);
    chk("rst_rs", 32'(dbg_rs_free), 16);
    chk("rst_lsb", 32'(dbg_lsb_free), 16);
  endtask

  task automatic test_lw();
    do_reset();
    id_valid = 1'b1; id_op = OP_LW; id_a = 32'h40; id_rd = 5'd7; id_pc = 32'h1000;
    #1;
    chk("lw_stall_before", 32'(id_stall), 0);
    chk("lw_no_early_dispatch", 32'(Dispatch_S), 0);
    tick();
    id_valid = 1'b0;
    #1;
    chk("lw_dispatch", 32'(Dispatch_S), 1);
    chk("lw_dis_op", 32'(dis_op), 32'(OP_LW));
    chk("lw_dis_a", dis_a, 32'h40);
    chk("lw_dis_rd", 32'(dis_rd), 7);
    chk("lw_dis_pc", dis_pc, 32'h1000);
    tick();
    chk("lw_lsb_free", 32'(dbg_lsb_free), 15);
    chk("lw_rob_free", 32'(dbg_rob_free), 15);
    chk("lw_rs_free", 32'(dbg_rs_free), 16);
    chk("lw_buf_empty", 32'(Dispatch_S), 0);
  endtask

  task automatic test_back_to_back();
    int dispatched;
    do_reset();
    dispatched = 0;
    id_valid = 1'b1; id_op = OP_ADD; id_pc = 32'd0;
    tick();
    for (int i = 0; i < 16; i++) begin
      id_pc = 32'((i + 1) * 4);
      #1;
      if (Dispatch_S === 1'b1 && dis_pc === 32'(i * 4)) dispatched++;
      tick();
    end
    chk("b2b_dispatch_count", 32'(dispatched), 16);
    id_pc = 32'd68;
    #1;
    chk("b2b_17_held", 32'(Dispatch_S), 0);
    chk("b2b_17_stall", 32'(id_stall), 1);
    chk("b2b_rs_empty", 32'(dbg_rs_free), 0);
    chk("b2b_rob_empty", 32'(dbg_rob_free), 0);
    rs_release = 1'b1; rob_release = 1'b1;
    tick();
    rs_release = 1'b0; rob_release = 1'b0; id_valid = 1'b0;
    #1;
    chk("b2b_17_go", 32'(Dispatch_S), 1);
    chk("b2b_17_pc", dis_pc, 32'd64);
    tick();
  endtask

  task automatic test_same_cycle();
    // Continues from back-to-back: all credits exhausted, buffer empty.
    rs_release = 1'b1; rob_release = 1'b1;
    id_valid = 1'b1; id_op = OP_ADD; id_pc = 32'd100;
    tick();
    chk("same_rs_one", 32'(dbg_rs_free), 1);
    id_pc = 32'd104;
    #1;
    chk("same_first_go", 32'(Dispatch_S), 1);
    tick();
    rs_release = 1'b0; rob_release = 1'b0; id_valid = 1'b0;
    #1;
    chk("same_rs_held", 32'(dbg_rs_free), 1);
    chk("same_rob_held", 32'(dbg_rob_free), 1);
    chk("same_next_go", 32'(Dispatch_S), 1);
    chk("same_next_pc", dis_pc, 32'd104);
    tick();
  endtask

  task automatic test_clear();
    do_reset();
    id_valid = 1'b1; id_op = OP_ADD; id_pc = 32'd0;
    tick();
    for (int i = 0; i < 13; i++) begin
      id_pc = 32'((i + 1) * 4);
      tick();
    end
    chk("clr_pre_rob", 32'(dbg_rob_free), 3);
    chk("clr_pre_buf", 32'(dbg_buf_valid), 1);
    clear = 1'b1; lsb_live_cnt = 5'd2; rs_release = 1'b1; id_pc = 32'd200;
    #1;
    chk("clr_no_dispatch", 32'(Dispatch_S), 0);
    chk("clr_stall_clear", 32'(id_stall), 1);
    tick();
    clear = 1'b0; rs_release = 1'b0; lsb_release = 1'b1;
    #1;
    chk("clr_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
    chk("clr_stall_flush", 32'(id_stall), 1);
    chk("clr_buf_dropped", 32'(dbg_buf_valid), 0);
    chk("clr_rob", 32'(dbg_rob_free), 16);
    chk("clr_rs", 32'(dbg_rs_free), 16);
    chk("clr_lsb", 32'(dbg_lsb_free), 14);
    chk("clr_release_ignored", 32'(credit_err), 0);
    tick();
    lsb_release = 1'b0; id_valid = 1'b0;
    #1;
    chk("clr_state_run", 32'(dbg_state), 32'(ST_RUN));
    chk("clr_stall_off", 32'(id_stall), 0);
    chk("clr_flush_release", 32'(dbg_lsb_free), 15);
    chk("clr_no_load_in_flush", 32'(dbg_buf_valid), 0);
  endtask

  task automatic test_rdy_freeze();
    int early;
    do_reset();
    early = 0;
    id_valid = 1'b1; id_op = OP_ADD; id_pc = 32'd8;
    tick();
    id_valid = 1'b0; rdy_in = 1'b0;
    rob_release = 1'b1; rs_release = 1'b1; lsb_release = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clear = (i == 2);
      #1;
      if (Dispatch_S !== 1'b0) early++;
      tick();
    end
    chk("rdy_no_dispatch", 32'(early), 0);
    rdy_in = 1'b1; clear = 1'b0;
    rob_release = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
    #1;
    chk("rdy_rob_frozen", 32'(dbg_rob_free), 16);
    chk("rdy_rs_frozen", 32'(dbg_rs_free), 16);
    chk("rdy_err_frozen", 32'(credit_err), 0);
    chk("rdy_clear_ignored", 32'(dbg_state), 32'(ST_RUN));
    chk("rdy_resume", 32'(Dispatch_S), 1);
    tick();
    chk("rdy_after_rob", 32'(dbg_rob_free), 15);
  endtask

  task automatic test_credit_err();
    do_reset();
    rob_release = 1'b1;
    tick();
    rob_release = 1'b0;
    chk("err_rob_sat", 32'(dbg_rob_free), 16);
    chk("err_set", 32'(credit_err), 1);
    tick();
    tick();
    chk("err_sticky", 32'(credit_err), 1);
    // Asynchronous reset mid-operation, away from any clock edge.
    id_valid = 1'b1; id_op = OP_SW; id_pc = 32'h55;
    tick();
    id_valid = 1'b0;
    #1;
    rst_in = 1'b1;
    #1;
    chk("arst_err", 32'(credit_err), 0);
    chk("arst_dispatch", 32'(Dispatch_S), 0);
    chk("arst_dis_pc", dis_pc, 0);
    chk("arst_dis_op", 32'(dis_op), 0);
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    test_reset();
    test_lw();
    test_back_to_back();
    test_same_cycle();
    test_clear();
    test_rdy_freeze();
    test_credit_err();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
